// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter_pkg
//  Description : Shared constants and state encoding for the I/D memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int IDX_W       = 3;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = IDX_W + 1;

    localparam logic [15:0] c_align_mask = 16'hFFF0;

    typedef logic [1:0] state_t;
    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_i_fill  = 2'd1;
    localparam state_t c_st_d_fill  = 2'd2;
    localparam state_t c_st_d_write = 2'd3;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_beat_counter
//  Description : Loadable saturating up-counter with terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_beat_counter
    import memory_arbiter_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int LIMIT = BLOCK_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !o_term) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == WIDTH'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares main memory between I-cache fills and D-cache fills/writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_data_valid,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic [15:0]      fill_data,
    output logic [IDX_W-1:0] fill_idx,
    output logic             i_fill_valid,
    output logic             d_fill_valid,
    output logic             i_done,
    output logic             d_done,
    output logic             i_mem_stall,
    output logic             d_mem_stall
);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_base;
    logic [15:0]      w_sel_addr;
    logic [CNT_W-1:0] w_issue_cnt;
    logic [CNT_W-1:0] w_ret_cnt;
    logic             w_issue_term;
    logic             w_ret_term;
    logic             w_idle;
    logic             w_in_fill;
    logic             w_issue;
    logic             w_beat;
    logic             w_last_beat;

    assign w_idle      = (r_state == c_st_idle);
    assign w_in_fill   = (r_state == c_st_i_fill) || (r_state == c_st_d_fill);
    assign w_issue     = w_in_fill && !w_issue_term;
    assign w_beat      = w_in_fill && mem_data_valid && !w_ret_term;
    assign w_last_beat = w_beat && (w_ret_cnt == CNT_W'(BLOCK_WORDS - 1));
    // D wins arbitration, so the latched base follows the same choice
    assign w_sel_addr  = d_req ? d_addr : i_addr;

    mem_beat_counter #(.WIDTH(CNT_W), .LIMIT(BLOCK_WORDS)) u_issue_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle),
        .i_load_val ('0),
        .i_inc      (w_issue),
        .o_count    (w_issue_cnt),
        .o_term     (w_issue_term)
    );

    mem_beat_counter #(.WIDTH(CNT_W), .LIMIT(BLOCK_WORDS)) u_ret_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle),
        .i_load_val ('0),
        .i_inc      (w_beat),
        .o_count    (w_ret_cnt),
        .o_term     (w_ret_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle) begin
                r_base <= w_sel_addr & c_align_mask;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (d_req) begin
                    w_next = d_we ? c_st_d_write : c_st_d_fill;
                end else if (i_req) begin
                    w_next = c_st_i_fill;
                end
            end
            c_st_i_fill, c_st_d_fill: begin
                if (w_last_beat) begin
                    w_next = c_st_idle;
                end
            end
            c_st_d_write: w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_data    = '0;
        fill_idx     = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = w_last_beat && (r_state == c_st_i_fill);
        d_done       = (w_last_beat && (r_state == c_st_d_fill)) || (r_state == c_st_d_write);
        if (w_issue) begin
            mem_en   = 1'b1;
            mem_addr = r_base + 16'({w_issue_cnt, 1'b0});
        end
        if (r_state == c_st_d_write) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
        if (w_beat) begin
            fill_data    = mem_rdata;
            fill_idx     = w_ret_cnt[IDX_W-1:0];
            i_fill_valid = (r_state == c_st_i_fill);
            d_fill_valid = (r_state == c_st_d_fill);
        end
    end

    assign i_mem_stall = (r_state == c_st_d_fill) || (r_state == c_st_d_write);
    assign d_mem_stall = (r_state == c_st_i_fill);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench with a latency-4 memory model and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic             clk;
    logic             rst;
    logic             i_req, d_req, d_we;
    logic [15:0]      i_addr, d_addr, d_wdata, mem_rdata;
    logic             mem_data_valid;
    logic             mem_en, mem_wr;
    logic [15:0]      mem_addr, mem_wdata, fill_data;
    logic [IDX_W-1:0] fill_idx;
    logic             i_fill_valid, d_fill_valid, i_done, d_done, i_mem_stall, d_mem_stall;

    memory_arbiter dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_data(fill_data), .fill_idx(fill_idx), .i_fill_valid(i_fill_valid),
        .d_fill_valid(d_fill_valid), .i_done(i_done), .d_done(d_done),
        .i_mem_stall(i_mem_stall), .d_mem_stall(d_mem_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic [15:0] i_addr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] exp_i_base;
        logic [15:0] exp_d_base;
    } txn_t;

    typedef struct {
        logic        owner_d;
        logic [2:0]  idx;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] issue_q[$];
    beat_t       beat_q[$];
    wr_t         wr_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    // memory return pipeline, slot 3 is presented next cycle
    logic        pv[4];
    logic [15:0] pd[4];
    logic        inject;

    // reference model of arbiter state
    int          mstate;
    int          missue;
    int          mret;
    logic        e_issue, e_beat, e_done;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C3C;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {5'd0, mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done,
                     i_mem_stall, d_mem_stall, mem_addr, mem_wdata, fill_data, fill_idx}, 64'd0);
    endtask

    task automatic push_fill(input logic owner_d, input logic [15:0] base);
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            logic [15:0] a;
            beat_t       b;
            a = base + 16'(2 * k);
            issue_q.push_back(a);
            b.owner_d = owner_d;
            b.idx     = 3'(k);
            b.data    = memfn(a);
            beat_q.push_back(b);
        end
    endtask

    task automatic model_reset();
        mstate  = 0;
        missue  = 0;
        mret    = 0;
        e_issue = 1'b0;
        e_beat  = 1'b0;
        e_done  = 1'b0;
    endtask

    task automatic step();
        logic       fill;
        logic [7:0] e_ctrl;
        // advance the model across the coming rising edge
        if (!rst) begin
            model_reset();
        end else begin
            case (mstate)
                0: begin
                    missue = 0;
                    mret   = 0;
                    if (d_req)      mstate = d_we ? 3 : 2;
                    else if (i_req) mstate = 1;
                end
                1, 2: begin
                    if (e_issue) missue++;
                    if (e_beat)  mret++;
                    if (e_done)  mstate = 0;
                end
                default: mstate = 0;
            endcase
        end
        @(negedge clk);
        cyc++;
        mem_data_valid = pv[3] | inject;
        mem_rdata      = pv[3] ? pd[3] : 16'h5A5A;
        inject         = 1'b0;
        for (int s = 3; s > 0; s--) begin
            pv[s] = pv[s-1];
            pd[s] = pd[s-1];
        end
        pv[0] = 1'b0;
        pd[0] = 16'h0;
        #1;
        fill    = (mstate == 1) || (mstate == 2);
        e_issue = fill && (missue < BLOCK_WORDS);
        e_beat  = fill && mem_data_valid;
        e_done  = (e_beat && (mret == BLOCK_WORDS - 1)) || (mstate == 3);
        e_ctrl  = {e_issue || (mstate == 3), mstate == 3, e_beat && (mstate == 1),
                   e_beat && (mstate == 2), e_done && (mstate == 1), e_done && (mstate != 1),
                   mstate >= 2, mstate == 1};
        check("ctrl", {56'd0, mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done,
                       i_mem_stall, d_mem_stall}, {56'd0, e_ctrl});
        if (mem_en && !mem_wr) begin
            if (issue_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_addr: got read at %h, required no read (cycle %0d)", mem_addr, cyc);
            end else begin
                check("issue_addr", {48'd0, mem_addr}, {48'd0, issue_q.pop_front()});
            end
            pv[0] = 1'b1;
            pd[0] = memfn(mem_addr);
        end
        if (mem_en && mem_wr) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL write: got write at %h, required no write (cycle %0d)", mem_addr, cyc);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("write", {32'd0, mem_addr, mem_wdata}, {32'd0, w.addr, w.data});
            end
        end
        if (i_fill_valid || d_fill_valid) begin
            if (beat_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat: got beat idx %0d, required no beat (cycle %0d)", fill_idx, cyc);
            end else begin
                beat_t b;
                b = beat_q.pop_front();
                check("beat", {44'd0, d_fill_valid, fill_idx, fill_data},
                              {44'd0, b.owner_d, b.idx, b.data});
            end
        end
    endtask

    task automatic run_txn(input txn_t t);
        int d_cyc;
        int first_i;
        if (t.d_req) begin
            if (t.d_we) begin
                wr_t w;
                w.addr = t.d_addr;
                w.data = t.d_wdata;
                wr_q.push_back(w);
            end else begin
                push_fill(1'b1, t.exp_d_base);
            end
        end
        if (t.i_req) push_fill(1'b0, t.exp_i_base);
        i_addr  = t.i_addr;
        d_addr  = t.d_addr;
        d_we    = t.d_we;
        d_wdata = t.d_wdata;
        i_req   = t.i_req;
        d_req   = t.d_req;
        d_cyc   = -1;
        first_i = -1;
        for (int n = 0; n < 80 && (i_req || d_req); n++) begin
            step();
            if (mem_en && !mem_wr && d_mem_stall && first_i < 0) first_i = cyc;
            if (d_done) begin
                d_req = 1'b0;
                d_cyc = cyc;
            end
            if (i_done) i_req = 1'b0;
        end
        if (i_req || d_req) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got request pending after 80 cycles, required done (cycle %0d)", cyc);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        step();
        check("q_empty", 64'(issue_q.size() + beat_q.size() + wr_q.size()), 64'd0);
        if (t.i_req && t.d_req) check("i_after_d", 64'(first_i - d_cyc), 64'd2);
        issue_q.delete();
        beat_q.delete();
        wr_q.delete();
    endtask

    txn_t tbl[6];

    initial begin
        int   beats;
        txn_t t;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0046, 16'h0000, 16'h0000, 16'h0040, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0300, 16'h1234, 16'h0000, 16'h0300, 16'h1230};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h2002, 16'hBEEF, 16'h0000, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 16'hFFFA, 16'h0000, 16'h0000, 16'hFFF0, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h00F0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h7777, 16'h3001, 16'h1234, 16'h7770, 16'h0000};

        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_data_valid = 1'b0; inject = 1'b0;
        for (int s = 0; s < 4; s++) begin
            pv[s] = 1'b0;
            pd[s] = 16'h0;
        end
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_all_zero("reset_state");
        step();
        step();
        check_all_zero("reset_held");
        rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // spurious valid while idle
        inject = 1'b1;
        step();
        check("spurious", {60'd0, i_fill_valid, d_fill_valid, i_done, d_done}, 64'd0);
        inject = 1'b1;
        step();
        step();

        // asynchronous reset after three returned beats
        i_addr = 16'h0510;
        i_req  = 1'b1;
        push_fill(1'b0, 16'h0510);
        beats = 0;
        for (int n = 0; n < 40 && beats < 3; n++) begin
            step();
            if (i_fill_valid) beats++;
        end
        check("beats_before_reset", 64'(beats), 64'd3);
        #2;
        rst   = 1'b0;
        i_req = 1'b0;
        #1;
        check_all_zero("async_reset");
        issue_q.delete();
        beat_q.delete();
        step();
        rst = 1'b1;
        repeat (8) step();
        t = '{1'b1, 1'b0, 1'b0, 16'h0806, 16'h0000, 16'h0000, 16'h0800, 16'h0000};
        run_txn(t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
